// File: rtl/out_data_misr.sv
// Signature stage: folds each accepted DATA_W-bit sample into a SIG_W-bit Galois MISR, then freezes it after SAMPLE_CNT samples.
// Latency: an accept at edge N is visible on sig/cnt from cycle N+1; done/match follow the final accept by one cycle.
// Backpressure: cap_ready is high only in RUN; samples offered in IDLE or DONE are dropped, and nothing is buffered.
//
// Ports: clkin_data/rst_n (clock, synchronous active-low reset), start (run pulse),
//        cap_valid/cap_ready/cap_data (sample handshake), exp_sig (expected signature),
//        sig/cnt (signature and accepted count), busy/done/match (run status).
// Optional feature macro: OUT_DATA_MISR_CMP_EN builds the final-signature comparator
// that drives match. Without it, match is tied low and exp_sig is ignored.
module out_data_misr #(
    parameter int unsigned        DATA_W     = 96,
    parameter int unsigned        SIG_W      = 32,
    parameter logic [SIG_W-1:0]   POLY       = 32'h04C11DB7,
    parameter logic [SIG_W-1:0]   SEED       = 32'hFFFFFFFF,
    parameter int unsigned        SAMPLE_CNT = 256
) (
    input  logic              clkin_data,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cap_valid,
    output logic              cap_ready,
    input  logic [DATA_W-1:0] cap_data,
    input  logic [SIG_W-1:0]  exp_sig,
    output logic [SIG_W-1:0]  sig,
    output logic [15:0]       cnt,
    output logic              busy,
    output logic              done,
    output logic              match
);

    localparam int unsigned NSLICE   = DATA_W / SIG_W;
    localparam logic [15:0] LAST_CNT = 16'(SAMPLE_CNT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [SIG_W-1:0] fold;
    logic [SIG_W-1:0] sig_next;
    logic             accept;
    logic             last_accept;

    // XOR-compress the wide sample down to one signature-width word.
    always_comb begin
        fold = '0;
        for (int i = 0; i < NSLICE; i++) begin
            fold = fold ^ cap_data[i*SIG_W +: SIG_W];
        end
    end

    // Galois step: shift left, fold the polynomial in when the MSB falls out.
    always_comb begin
        sig_next = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ fold;
    end

    // busy is a flop that mirrors RUN, so cap_ready is registered as well.
    assign cap_ready   = busy;
    assign accept      = cap_valid & (state == RUN);
    assign last_accept = accept & (cnt == LAST_CNT);

    always_ff @(posedge clkin_data) begin
        if (!rst_n) begin
            state <= IDLE;
            sig   <= SEED;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        sig   <= SEED;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    // start is deliberately ignored here: a run must complete first.
                    if (accept) begin
                        sig <= sig_next;
                        cnt <= cnt + 16'd1;
                        if (last_accept) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // Restart takes priority; a coincident sample is dropped since
                    // cap_ready is still low in this cycle.
                    if (start) begin
                        state <= RUN;
                        sig   <= SEED;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef OUT_DATA_MISR_CMP_EN
    // Compare against the signature being written on the final accept, so
    // match becomes valid in the same cycle that done rises.
    always_ff @(posedge clkin_data) begin
        if (!rst_n) begin
            match <= 1'b0;
        end else if (start && (state != RUN)) begin
            match <= 1'b0;
        end else if (last_accept) begin
            match <= (sig_next == exp_sig);
        end
    end
`else
    logic unused_exp_sig;
    assign unused_exp_sig = ^exp_sig;
    assign match          = 1'b0;
`endif

endmodule
